// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: shared frame geometry, word-select encoding and slot bit helper
package i2s_tx_pkg;
    localparam int SLOT_BITS = 32;
    localparam int FRAME_BITS = 64;
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam int POS_W = $clog2(SLOT_BITS);
    typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} lr_e;
    // p=0 is the I2S one-bit delay; sample sits MSB-first in p=1..w
    function automatic logic slot_bit(input logic [30:0] f, input logic [POS_W-1:0] p, input logic [4:0] w);
        return (p != '0 && p <= w) ? f[w - p] : 1'b0;
    endfunction
endpackage

// File: rtl/i2s_tx_clkgen.sv
// i2s_tx_clkgen: SCLK divider and frame bit counter with fall/frame strobes
module i2s_tx_clkgen
    import i2s_tx_pkg::*;
#(
    parameter int SCLK_HALF = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    output logic             sclk,
    output logic [BIT_W-1:0] nxt_bit,
    output logic             fall_evt,
    output logic             frame_start
);
    localparam int DW = $clog2(SCLK_HALF);
    logic [DW-1:0]    div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             wrap;
    assign wrap        = Enable && div_cnt == DW'(SCLK_HALF - 1);
    assign fall_evt    = wrap && sclk;
    assign frame_start = fall_evt && bit_cnt == BIT_W'(FRAME_BITS - 1);
    assign nxt_bit     = bit_cnt + 1'b1;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= BIT_W'(FRAME_BITS - 1);
        end else if (!Enable) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= BIT_W'(FRAME_BITS - 1);
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) sclk <= ~sclk;
            if (fall_evt) bit_cnt <= nxt_bit;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: mono PCM to I2S serializer with one-sample hold and underrun flag
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int SCLK_HALF = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [SAMPLE_W-1:0] In_Data,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic                Clr_Underrun,
    output logic                SCLK,
    output logic                LRCK,
    output logic                SDIN,
    output logic                Frame_Tick,
    output logic                Underrun
);
    logic [BIT_W-1:0]    nxt_bit;
    logic                fall_evt;
    logic                frame_start;
    logic                hold_full;
    logic                accept;
    logic [SAMPLE_W-1:0] hold;
    logic [SAMPLE_W-1:0] frame;

    i2s_tx_clkgen #(.SCLK_HALF(SCLK_HALF)) u_clkgen (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .sclk        (SCLK),
        .nxt_bit     (nxt_bit),
        .fall_evt    (fall_evt),
        .frame_start (frame_start)
    );

    assign In_Ready = ~hold_full;
    assign accept   = In_Valid && ~hold_full;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hold_full  <= 1'b0;
            hold       <= '0;
            frame      <= '0;
            LRCK       <= 1'b0;
            SDIN       <= 1'b0;
            Frame_Tick <= 1'b0;
            Underrun   <= 1'b0;
        end else begin
            Frame_Tick <= frame_start;
            hold_full  <= accept | (hold_full & ~frame_start);
            if (accept) hold <= In_Data;
            // set wins over a same-cycle clear
            Underrun   <= (frame_start & ~hold_full) | (Underrun & ~Clr_Underrun);
            if (!Enable) begin
                frame <= '0;
                LRCK  <= 1'b0;
                SDIN  <= 1'b0;
            end else if (fall_evt) begin
                LRCK <= nxt_bit[BIT_W-1] ? RIGHT : LEFT;
                SDIN <= slot_bit(31'(frame), nxt_bit[POS_W-1:0], 5'(SAMPLE_W));
                if (frame_start) frame <= hold_full ? hold : '0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed scenario checks of the I2S serializer at SCLK_HALF=2
module tb_i2s_tx;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Enable = 1'b1;
    logic [15:0] In_Data = '0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic        Clr_Underrun = 1'b0;
    logic        SCLK, LRCK, SDIN, Frame_Tick, Underrun;
    int          passed = 0;
    int          total = 0;

    localparam logic [63:0] LR_EXP = {32'h0, 32'hFFFF_FFFF};

    i2s_tx #(.SAMPLE_W(16), .SCLK_HALF(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Enable       (Enable),
        .In_Data      (In_Data),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .Clr_Underrun (Clr_Underrun),
        .SCLK         (SCLK),
        .LRCK         (LRCK),
        .SDIN         (SDIN),
        .Frame_Tick   (Frame_Tick),
        .Underrun     (Underrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] exp_frame(input logic [15:0] s);
        return {1'b0, s, 15'b0, 1'b0, s, 15'b0};
    endfunction

    task automatic do_reset;
        In_Valid = 1'b0;
        Clr_Underrun = 1'b0;
        Enable = 1'b1;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Frame_Tick && n < 400);
        if (!Frame_Tick) begin
            total++;
            $display("FAIL tick_timeout: no Frame_Tick within %0d cycles", n);
        end
    endtask

    task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr);
        for (int k = 0; k < 64; k++) begin
            if (k > 0) repeat (4) @(negedge Clk);
            sd[63-k] = SDIN;
            lr[63-k] = LRCK;
        end
    endtask

    task automatic push(input logic [15:0] d);
        In_Data = d;
        In_Valid = 1'b1;
        @(posedge Clk);
        #1 In_Valid = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if ({SCLK, LRCK, SDIN, Frame_Tick, Underrun, In_Ready} !== 6'b000001)
            $display("FAIL reset_outputs: got %b want 000001", {SCLK, LRCK, SDIN, Frame_Tick, Underrun, In_Ready});
        else passed++;
    endtask

    task automatic test_idle_underrun;
        int n;
        logic [63:0] sd, lr;
        do_reset;
        Reset = 1'b1;
        wait_tick(n);
        total++;
        if (n !== 4) $display("FAIL idle_first_tick: got %0d cycles want 4", n); else passed++;
        total++;
        if (Underrun !== 1'b1) $display("FAIL idle_underrun: got %b want 1", Underrun); else passed++;
        capture_frame(sd, lr);
        total++;
        if (sd !== 64'h0) $display("FAIL idle_sdin: got %h want 0", sd); else passed++;
        total++;
        if (lr !== LR_EXP) $display("FAIL idle_lrck: got %h want %h", lr, LR_EXP); else passed++;
        wait_tick(n);
        total++;
        if (252 + n !== 256) $display("FAIL tick_period: got %0d want 256", 252 + n); else passed++;
        @(negedge Clk);
        total++;
        if (Frame_Tick !== 1'b0) $display("FAIL tick_width: got %b want 0", Frame_Tick); else passed++;
    endtask

    task automatic test_single;
        int n;
        logic [63:0] sd, lr;
        do_reset;
        Reset = 1'b1;
        push(16'hA5C3);
        total++;
        if (In_Ready !== 1'b0) $display("FAIL single_ready_drop: got %b want 0", In_Ready); else passed++;
        wait_tick(n);
        total++;
        if (In_Ready !== 1'b1) $display("FAIL single_ready_back: got %b want 1", In_Ready); else passed++;
        capture_frame(sd, lr);
        total++;
        if (sd !== exp_frame(16'hA5C3)) $display("FAIL single_sdin: got %h want %h", sd, exp_frame(16'hA5C3)); else passed++;
        total++;
        if (Underrun !== 1'b0) $display("FAIL single_underrun: got %b want 0", Underrun); else passed++;
    endtask

    task automatic test_stream;
        int off, nf, acc;
        logic pend;
        logic [15:0] w;
        logic [15:0] got [4];
        do_reset;
        Reset = 1'b1;
        In_Data = 16'h0001;
        In_Valid = 1'b1;
        pend = 1'b0;
        acc = 0;
        off = -1;
        nf = 0;
        w = '0;
        for (int c = 0; c < 1400 && nf < 4; c++) begin
            if (c > 0) @(negedge Clk);
            if (pend) In_Data = In_Data + 16'h1;
            pend = In_Ready;
            if (In_Ready) acc++;
            if (Frame_Tick) off = 0;
            else if (off >= 0) off++;
            if (off >= 4 && off <= 64 && off % 4 == 0) w[16 - off / 4] = SDIN;
            if (off == 64) begin
                got[nf] = w;
                nf++;
            end
        end
        In_Valid = 1'b0;
        total++;
        if (nf !== 4) $display("FAIL stream_frames: got %0d frames want 4", nf); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got[i] !== 16'(i + 1)) $display("FAIL stream_data%0d: got %h want %h", i, got[i], 16'(i + 1)); else passed++;
        end
        total++;
        if (acc !== 5) $display("FAIL stream_accepts: got %0d want 5", acc); else passed++;
        total++;
        if (Underrun !== 1'b0) $display("FAIL stream_underrun: got %b want 0", Underrun); else passed++;
    endtask

    task automatic test_underrun_clear;
        int n;
        logic [63:0] sd, lr;
        do_reset;
        Reset = 1'b1;
        push(16'h1234);
        wait_tick(n);
        capture_frame(sd, lr);
        total++;
        if (sd !== exp_frame(16'h1234)) $display("FAIL ur_first_frame: got %h want %h", sd, exp_frame(16'h1234)); else passed++;
        wait_tick(n);
        total++;
        if (Underrun !== 1'b1) $display("FAIL ur_set: got %b want 1", Underrun); else passed++;
        capture_frame(sd, lr);
        total++;
        if (sd !== 64'h0) $display("FAIL ur_zero_frame: got %h want 0", sd); else passed++;
        Clr_Underrun = 1'b1;
        push(16'h5678);
        Clr_Underrun = 1'b0;
        total++;
        if (Underrun !== 1'b0) $display("FAIL ur_cleared: got %b want 0", Underrun); else passed++;
        wait_tick(n);
        capture_frame(sd, lr);
        total++;
        if (sd !== exp_frame(16'h5678)) $display("FAIL ur_fed_frame: got %h want %h", sd, exp_frame(16'h5678)); else passed++;
        total++;
        if (Underrun !== 1'b0) $display("FAIL ur_stays_clear: got %b want 0", Underrun); else passed++;
        repeat (3) @(negedge Clk);
        Clr_Underrun = 1'b1;
        @(negedge Clk);
        Clr_Underrun = 1'b0;
        total++;
        if ({Frame_Tick, Underrun} !== 2'b11) $display("FAIL ur_set_wins: got %b want 11", {Frame_Tick, Underrun}); else passed++;
    endtask

    task automatic test_enable_drop;
        int n;
        logic [63:0] sd, lr;
        do_reset;
        Reset = 1'b1;
        push(16'h1111);
        wait_tick(n);
        push(16'hBEEF);
        repeat (162) @(negedge Clk);
        total++;
        if ({SCLK, LRCK, SDIN} !== 3'b111) $display("FAIL en_before_drop: got %b want 111", {SCLK, LRCK, SDIN}); else passed++;
        Enable = 1'b0;
        @(negedge Clk);
        total++;
        if ({SCLK, LRCK, SDIN, In_Ready} !== 4'b0000) $display("FAIL en_dropped: got %b want 0000", {SCLK, LRCK, SDIN, In_Ready}); else passed++;
        repeat (5) @(negedge Clk);
        Enable = 1'b1;
        wait_tick(n);
        total++;
        if (n !== 4) $display("FAIL en_restart_tick: got %0d cycles want 4", n); else passed++;
        total++;
        if ({In_Ready, Underrun} !== 2'b10) $display("FAIL en_restart_flags: got %b want 10", {In_Ready, Underrun}); else passed++;
        capture_frame(sd, lr);
        total++;
        if (sd !== exp_frame(16'hBEEF)) $display("FAIL en_held_frame: got %h want %h", sd, exp_frame(16'hBEEF)); else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        logic [63:0] sd, lr;
        do_reset;
        Reset = 1'b1;
        push(16'h2222);
        wait_tick(n);
        push(16'h3333);
        repeat (82) @(negedge Clk);
        total++;
        if ({SCLK, In_Ready} !== 2'b10) $display("FAIL rst_mid_before: got %b want 10", {SCLK, In_Ready}); else passed++;
        #1 Reset = 1'b0;
        #1;
        total++;
        if ({SCLK, LRCK, SDIN, Frame_Tick, Underrun, In_Ready} !== 6'b000001)
            $display("FAIL rst_mid_async: got %b want 000001", {SCLK, LRCK, SDIN, Frame_Tick, Underrun, In_Ready});
        else passed++;
        @(negedge Clk);
        Reset = 1'b1;
        wait_tick(n);
        total++;
        if ({Underrun, n == 4} !== 2'b11) $display("FAIL rst_mid_first_tick: got underrun=%b cycles=%0d want 1 and 4", Underrun, n); else passed++;
        capture_frame(sd, lr);
        total++;
        if (sd !== 64'h0) $display("FAIL rst_mid_frame: got %h want 0", sd); else passed++;
    endtask

    initial begin
        test_reset;
        test_idle_underrun;
        test_single;
        test_stream;
        test_underrun_clear;
        test_enable_drop;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
